// File: rtl/debug_tx_dump_pkg.sv
// debug_tx_dump_pkg
//   Shared constants and helpers for the debug context-dump serializer.
//   Contents:
//     UART_BYTE       - width of one UART character
//     dump_state_e    - serializer state encoding (IDLE, LOAD, SEND, WAIT, DONE)
//     dump_words()    - words per dump: PC + register file + data-memory window
//     index_width()   - bits needed to index every dumped word
//     bytes_per_word()- UART characters per data word
//     count_width()   - bits needed for the per-word byte counter
package debug_tx_dump_pkg;

    localparam int UART_BYTE = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    function automatic int dump_words(input int rf_depth, input int dm_depth);
        return 32'sd1 + rf_depth + dm_depth;
    endfunction

    function automatic int index_width(input int words);
        return (words > 32'sd1) ? $clog2(words) : 32'sd1;
    endfunction

    function automatic int bytes_per_word(input int nbits);
        return nbits / UART_BYTE;
    endfunction

    function automatic int count_width(input int bpw);
        return (bpw > 32'sd1) ? $clog2(bpw) : 32'sd1;
    endfunction

endpackage

// File: rtl/debug_tx_dump.sv
// debug_tx_dump
//   Serializes a fixed processor-context dump over a byte-wide UART TX
//   handshake once the debug controller raises send_flag: the PC, every
//   register-file word, then a window of data-memory words, each word sent
//   most-significant byte first.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   send_flag           - dump request, acted on at a 0->1 transition in IDLE
//   pc_value            - PC, sampled when word 0 is loaded
//   rf_data / rf_addr   - register-file debug read port (combinational read)
//   dm_data / dm_addr   - data-memory debug read port (combinational read)
//   tx_data, tx_start   - byte to send and its one-cycle start pulse
//   tx_done             - one-cycle pulse from the UART: byte shifted out
//   send_done           - 1 while idle / complete, 0 while a dump is running
module debug_tx_dump
    import debug_tx_dump_pkg::*;
#(
    parameter int NBITS          = 32,
    parameter int RF_DEPTH       = 32,
    parameter int RF_ADDR_LENGTH = 5,
    parameter int DM_DEPTH       = 32,
    parameter int DM_ADDR_LENGTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      send_flag,
    input  logic [NBITS-1:0]          pc_value,
    input  logic [NBITS-1:0]          rf_data,
    input  logic [NBITS-1:0]          dm_data,
    input  logic                      tx_done,
    output logic [RF_ADDR_LENGTH-1:0] rf_addr,
    output logic [DM_ADDR_LENGTH-1:0] dm_addr,
    output logic [7:0]                tx_data,
    output logic                      tx_start,
    output logic                      send_done
);

    localparam int WORDS = dump_words(RF_DEPTH, DM_DEPTH);
    localparam int IDX_W = index_width(WORDS);
    localparam int BPW   = bytes_per_word(NBITS);
    localparam int BC_W  = count_width(BPW);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 32'sd1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BPW - 32'sd1);

    dump_state_e       state_r;
    logic [IDX_W-1:0]  index_r;
    logic [BC_W-1:0]   byte_cnt_r;
    logic [NBITS-1:0]  shift_r;
    logic              flag_prev_r;

    logic [NBITS-1:0]  word_sel_s;
    logic [IDX_W-1:0]  index_inc_s;

    // Register-file address for a dump index (indices 1..RF_DEPTH map to 0..RF_DEPTH-1).
    function automatic logic [RF_ADDR_LENGTH-1:0] rf_addr_of(input logic [IDX_W-1:0] idx);
        if ((32'(idx) >= 32'd1) && (32'(idx) <= 32'(RF_DEPTH))) begin
            return RF_ADDR_LENGTH'(32'(idx) - 32'd1);
        end else begin
            return {RF_ADDR_LENGTH{1'b0}};
        end
    endfunction

    // Data-memory word address for a dump index (indices after the register file).
    function automatic logic [DM_ADDR_LENGTH-1:0] dm_addr_of(input logic [IDX_W-1:0] idx);
        if (32'(idx) > 32'(RF_DEPTH)) begin
            return DM_ADDR_LENGTH'(32'(idx) - 32'd1 - 32'(RF_DEPTH));
        end else begin
            return {DM_ADDR_LENGTH{1'b0}};
        end
    endfunction

    // Select the source word for the current index; read ports are already
    // addressed because addresses are updated together with the index.
    always_comb begin
        word_sel_s = pc_value;
        if (index_r == {IDX_W{1'b0}}) begin
            word_sel_s = pc_value;
        end else if (32'(index_r) <= 32'(RF_DEPTH)) begin
            word_sel_s = rf_data;
        end else begin
            word_sel_s = dm_data;
        end
    end

    // Next word index, used when advancing across a word boundary.
    always_comb begin
        index_inc_s = index_r + IDX_W'(1);
    end

    // Dump sequencer: edge detect, word load, byte send/wait, completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            index_r     <= {IDX_W{1'b0}};
            byte_cnt_r  <= {BC_W{1'b0}};
            shift_r     <= {NBITS{1'b0}};
            flag_prev_r <= 1'b0;
            rf_addr     <= {RF_ADDR_LENGTH{1'b0}};
            dm_addr     <= {DM_ADDR_LENGTH{1'b0}};
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            send_done   <= 1'b1;
        end else begin
            flag_prev_r <= send_flag;
            tx_start    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    send_done <= 1'b1;
                    if (send_flag && !flag_prev_r) begin
                        index_r   <= {IDX_W{1'b0}};
                        rf_addr   <= {RF_ADDR_LENGTH{1'b0}};
                        dm_addr   <= {DM_ADDR_LENGTH{1'b0}};
                        send_done <= 1'b0;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_r    <= word_sel_s;
                    byte_cnt_r <= {BC_W{1'b0}};
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= shift_r[NBITS-1 -: UART_BYTE];
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A tx_done coinciding with our own start pulse belongs
                    // to no byte of ours and is dropped.
                    if (tx_done && !tx_start) begin
                        shift_r    <= shift_r << UART_BYTE;
                        byte_cnt_r <= byte_cnt_r + BC_W'(1);
                        if (byte_cnt_r != LAST_BYTE) begin
                            state_r <= ST_SEND;
                        end else if (index_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                        end else begin
                            index_r <= index_inc_s;
                            rf_addr <= rf_addr_of(index_inc_s);
                            dm_addr <= dm_addr_of(index_inc_s);
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    send_done <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    send_done <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
